// File: rtl/pipe_hazard_ctrl_pkg.sv
// rtl/pipe_hazard_ctrl_pkg.sv - shared types and helpers for the pipeline hazard controller
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_FREEZE = 2'd1,
    ST_HALT   = 2'd2
  } state_e;

  localparam logic [4:0] X0 = 5'd0;

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       wr;
    logic       ld;
  } sb_entry_t;

  // x0 is hardwired, so a writer of x0 can never produce a RAW dependency
  function automatic logic writes_reg(input sb_entry_t e, input logic [4:0] rs);
    return e.v && e.wr && (e.rd == rs) && (rs != X0);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - decode-side inputs and stage control outputs of the hazard controller
interface pipe_hazard_ctrl_if #(parameter int CNT_W = 32);
  logic             id_valid;
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic [4:0]       id_rd;
  logic             id_wr_rd;
  logic             id_is_load;
  logic             id_illegal;
  logic             ex_redirect;
  logic             mem_busy;
  logic             pc_en;
  logic             if_id_en;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             ex_mem_en;
  logic             mem_wb_en;
  logic             pc_sel_tgt;
  logic             halted;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_wr_rd,
           id_is_load, id_illegal, ex_redirect, mem_busy,
    input  pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_en, mem_wb_en,
           pc_sel_tgt, halted, state, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_wr_rd,
           id_is_load, id_illegal, ex_redirect, mem_busy,
    output pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_en, mem_wb_en,
           pc_sel_tgt, halted, state, stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl_scoreboard.sv
// rtl/pipe_hazard_ctrl_scoreboard.sv - EX/MEM/WB destination tracking and RAW match logic
module pipe_scoreboard
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter bit FWD_EN    = 1'b1,
  parameter bit RF_BYPASS = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       shift_en,
  input  logic       ex_bubble,
  input  logic       id_valid,
  input  logic [4:0] id_rd,
  input  logic       id_wr,
  input  logic       id_ld,
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  output logic       rs1_match,
  output logic       rs2_match
);

  sb_entry_t ex_q, mem_q, wb_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else if (shift_en) begin
      ex_q  <= '{v: id_valid && !ex_bubble, rd: id_rd, wr: id_wr, ld: id_ld};
      mem_q <= ex_q;
      wb_q  <= mem_q;
    end
  end

  // With forwarding only a load in EX is too late; without it any EX/MEM writer stalls
  always_comb begin
    rs1_match = (writes_reg(ex_q, rs1) && (ex_q.ld || !FWD_EN))
             || (!FWD_EN && writes_reg(mem_q, rs1))
             || (!RF_BYPASS && writes_reg(wb_q, rs1));
    rs2_match = (writes_reg(ex_q, rs2) && (ex_q.ld || !FWD_EN))
             || (!FWD_EN && writes_reg(mem_q, rs2))
             || (!RF_BYPASS && writes_reg(wb_q, rs2));
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline sequencer: hazard stalls, freeze, redirect squash, halt, stall counter
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter bit FWD_EN    = 1'b1,
  parameter bit RF_BYPASS = 1'b1,
  parameter int CNT_W     = 32
) (
  input  logic               clk,
  input  logic               reset,
  pipe_hazard_ctrl_if.slave  bus
);

  state_e           state_q, state_d;
  logic             rs1_match, rs2_match;
  logic             hazard, illegal;
  logic             pc_en, if_id_en, if_id_flush, id_ex_flush;
  logic             ex_mem_en, mem_wb_en, pc_sel_tgt;
  logic [CNT_W-1:0] stall_cnt_q;

  pipe_scoreboard #(.FWD_EN(FWD_EN), .RF_BYPASS(RF_BYPASS)) u_sb (
    .clk       (clk),
    .reset     (reset),
    .shift_en  (mem_wb_en),
    .ex_bubble (id_ex_flush),
    .id_valid  (bus.id_valid),
    .id_rd     (bus.id_rd),
    .id_wr     (bus.id_wr_rd),
    .id_ld     (bus.id_is_load),
    .rs1       (bus.id_rs1),
    .rs2       (bus.id_rs2),
    .rs1_match (rs1_match),
    .rs2_match (rs2_match)
  );

  assign hazard  = bus.id_valid && ((bus.id_use_rs1 && rs1_match) || (bus.id_use_rs2 && rs2_match));
  assign illegal = bus.id_valid && bus.id_illegal;

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_RUN;
    else       state_q <= state_d;
  end

  // FREEZE with mem_busy released decodes exactly like RUN
  always_comb begin
    state_d     = state_q;
    pc_en       = 1'b0;
    if_id_en    = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    ex_mem_en   = 1'b0;
    mem_wb_en   = 1'b0;
    pc_sel_tgt  = 1'b0;
    if (reset) begin
      state_d     = ST_RUN;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (state_q == ST_HALT) begin
      id_ex_flush = 1'b1;
      ex_mem_en   = 1'b1;
      mem_wb_en   = 1'b1;
    end else if (bus.mem_busy) begin
      state_d = ST_FREEZE;
    end else begin
      state_d   = ST_RUN;
      ex_mem_en = 1'b1;
      mem_wb_en = 1'b1;
      if (bus.ex_redirect) begin
        pc_sel_tgt  = 1'b1;
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (hazard || illegal) begin
        id_ex_flush = 1'b1;
        if (illegal) state_d = ST_HALT;
      end else begin
        pc_en    = 1'b1;
        if_id_en = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                               stall_cnt_q <= '0;
    else if (!pc_en && state_q != ST_HALT)   stall_cnt_q <= stall_cnt_q + 1'b1;
  end

  assign bus.pc_en       = pc_en;
  assign bus.if_id_en    = if_id_en;
  assign bus.if_id_flush = if_id_flush;
  assign bus.id_ex_flush = id_ex_flush;
  assign bus.ex_mem_en   = ex_mem_en;
  assign bus.mem_wb_en   = mem_wb_en;
  assign bus.pc_sel_tgt  = pc_sel_tgt;
  assign bus.halted      = !reset && (state_q == ST_HALT);
  assign bus.state       = reset ? 2'(ST_RUN) : 2'(state_q);
  assign bus.stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - table-driven scoreboard bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

  typedef struct packed {
    logic       rst;
    logic       vld;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       wr;
    logic       ld;
    logic       ill;
    logic       rdr;
    logic       busy;
  } stim_t;

  typedef struct packed {
    logic [7:0]  ctl;
    logic [1:0]  st;
    logic [31:0] cnt;
  } exp_t;

  typedef struct {
    stim_t s;
    exp_t  e;
  } vec_t;

  // {pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_en, mem_wb_en, pc_sel_tgt, halted}
  localparam logic [7:0] NRM = 8'b1100_1100;
  localparam logic [7:0] HAZ = 8'b0001_1100;
  localparam logic [7:0] FRZ = 8'b0000_0000;
  localparam logic [7:0] RDR = 8'b1111_1110;
  localparam logic [7:0] RST = 8'b0011_0000;
  localparam logic [7:0] HLT = 8'b0001_1101;

  logic  clk = 1'b0;
  logic  reset;
  stim_t cur;
  int    n_tests = 0;
  int    n_fail  = 0;
  vec_t  vecs[$];
  exp_t  expq[$];

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.CNT_W(32)) bus1 ();
  pipe_hazard_ctrl_if #(.CNT_W(2))  bus0 ();

  pipe_hazard_ctrl #(.FWD_EN(1'b1), .RF_BYPASS(1'b1), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .bus(bus1)
  );

  pipe_hazard_ctrl #(.FWD_EN(1'b0), .RF_BYPASS(1'b1), .CNT_W(2)) dut_nofwd (
    .clk(clk), .reset(reset), .bus(bus0)
  );

  assign reset = cur.rst;
  assign bus1.id_valid = cur.vld;  assign bus0.id_valid = cur.vld;
  assign bus1.id_rs1 = cur.rs1;    assign bus0.id_rs1 = cur.rs1;
  assign bus1.id_rs2 = cur.rs2;    assign bus0.id_rs2 = cur.rs2;
  assign bus1.id_use_rs1 = cur.u1; assign bus0.id_use_rs1 = cur.u1;
  assign bus1.id_use_rs2 = cur.u2; assign bus0.id_use_rs2 = cur.u2;
  assign bus1.id_rd = cur.rd;      assign bus0.id_rd = cur.rd;
  assign bus1.id_wr_rd = cur.wr;   assign bus0.id_wr_rd = cur.wr;
  assign bus1.id_is_load = cur.ld; assign bus0.id_is_load = cur.ld;
  assign bus1.id_illegal = cur.ill;  assign bus0.id_illegal = cur.ill;
  assign bus1.ex_redirect = cur.rdr; assign bus0.ex_redirect = cur.rdr;
  assign bus1.mem_busy = cur.busy;   assign bus0.mem_busy = cur.busy;

  function automatic stim_t stim(input logic rst, vld, input logic [4:0] rs1, rs2,
                                 input logic u1, u2, input logic [4:0] rd,
                                 input logic wr, ld, ill, rdr, busy);
    return '{rst: rst, vld: vld, rs1: rs1, rs2: rs2, u1: u1, u2: u2, rd: rd,
             wr: wr, ld: ld, ill: ill, rdr: rdr, busy: busy};
  endfunction

  function automatic exp_t ex(input logic [7:0] ctl, input logic [1:0] st, input logic [31:0] cnt);
    return '{ctl: ctl, st: st, cnt: cnt};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic step(input stim_t s);
    @(posedge clk);
    #1 cur = s;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    stim_t idle, busy, lw5, add6, addi5, add6b;
    exp_t  e;
    idle  = stim(0,0,0,0,0,0,0,0,0,0,0,0);
    busy  = stim(0,0,0,0,0,0,0,0,0,0,0,1);
    lw5   = stim(0,1,1,0,1,0,5,1,1,0,0,0);
    add6  = stim(0,1,5,1,1,1,6,1,0,0,0,0);
    addi5 = stim(0,1,1,0,1,0,5,1,0,0,0,0);
    add6b = stim(0,1,5,5,1,1,6,1,0,0,0,0);

    vecs.push_back('{stim(1,0,0,0,0,0,0,0,0,0,0,0), ex(RST,0,0)});
    vecs.push_back('{idle, ex(NRM,0,0)});
    vecs.push_back('{lw5,  ex(NRM,0,0)});
    vecs.push_back('{add6, ex(HAZ,0,0)});                                // load-use bubble
    vecs.push_back('{add6, ex(NRM,0,1)});
    vecs.push_back('{stim(0,1,6,6,1,1,7,1,0,0,0,0), ex(NRM,0,1)});     // ALU result forwarded
    vecs.push_back('{stim(0,1,1,0,1,0,0,1,1,0,0,0), ex(NRM,0,1)});     // LW x0
    vecs.push_back('{stim(0,1,0,0,1,1,6,1,0,0,0,0), ex(NRM,0,1)});     // ADD x6,x0,x0
    vecs.push_back('{stim(0,1,2,0,1,0,9,1,1,0,0,0), ex(NRM,0,1)});     // LW x9
    vecs.push_back('{stim(0,1,3,9,1,1,10,1,0,0,1,0), ex(RDR,0,1)});    // redirect beats hazard
    vecs.push_back('{stim(0,1,3,9,1,1,10,1,0,0,0,0), ex(NRM,0,1)});
    vecs.push_back('{stim(0,1,2,0,1,0,9,1,1,0,0,0), ex(NRM,0,1)});
    vecs.push_back('{stim(0,1,9,3,0,1,11,1,0,0,0,0), ex(NRM,0,1)});    // rs1 matches but unused
    vecs.push_back('{stim(0,1,2,0,1,0,12,1,1,0,0,0), ex(NRM,0,1)});    // LW x12
    vecs.push_back('{stim(0,1,12,0,1,0,13,1,0,0,0,1), ex(FRZ,0,1)});
    vecs.push_back('{stim(0,1,12,0,1,0,13,1,0,0,0,1), ex(FRZ,1,2)});
    vecs.push_back('{stim(0,1,12,0,1,0,13,1,0,0,0,1), ex(FRZ,1,3)});
    vecs.push_back('{stim(0,1,12,0,1,0,13,1,0,0,0,0), ex(HAZ,1,4)});
    vecs.push_back('{stim(0,1,12,0,1,0,13,1,0,0,0,0), ex(NRM,0,5)});
    vecs.push_back('{stim(0,1,0,0,0,0,0,0,0,1,1,0), ex(RDR,0,5)});     // wrong-path illegal squashed
    vecs.push_back('{stim(0,0,0,0,0,0,0,0,0,1,0,0), ex(NRM,0,5)});     // illegal without valid ignored
    vecs.push_back('{stim(0,1,0,0,0,0,0,0,0,1,0,0), ex(HAZ,0,5)});
    vecs.push_back('{stim(0,1,1,2,1,1,3,1,0,0,0,0), ex(HLT,2,6)});
    vecs.push_back('{busy, ex(HLT,2,6)});
    vecs.push_back('{stim(1,0,0,0,0,0,0,0,0,0,0,0), ex(RST,0,6)});
    vecs.push_back('{idle, ex(NRM,0,0)});

    cur = stim(1,0,0,0,0,0,0,0,0,0,0,0);
    repeat (3) @(posedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      expq.push_back(vecs[i].e);
      step(vecs[i].s);
      e = expq.pop_front();
      chk($sformatf("row%0d ctl", i),
          {bus1.pc_en, bus1.if_id_en, bus1.if_id_flush, bus1.id_ex_flush,
           bus1.ex_mem_en, bus1.mem_wb_en, bus1.pc_sel_tgt, bus1.halted}, e.ctl);
      chk($sformatf("row%0d state", i), bus1.state, e.st);
      chk($sformatf("row%0d stall_cnt", i), bus1.stall_cnt, e.cnt);
    end

    // Without forwarding an ALU producer costs two bubbles; 2-bit counter wraps
    step(addi5);
    chk("nofwd addi pc_en", bus0.pc_en, 1);
    step(add6b);
    chk("nofwd raw ex pc_en", bus0.pc_en, 0);
    chk("nofwd raw ex flush", bus0.id_ex_flush, 1);
    chk("fwd alu no stall", bus1.pc_en, 1);
    step(add6b);
    chk("nofwd raw mem pc_en", bus0.pc_en, 0);
    chk("nofwd cnt1", bus0.stall_cnt, 1);
    step(add6b);
    chk("nofwd issue pc_en", bus0.pc_en, 1);
    chk("nofwd cnt2", bus0.stall_cnt, 2);
    step(busy);
    chk("nofwd busy ex_mem_en", bus0.ex_mem_en, 0);
    step(busy);
    chk("nofwd cnt3", bus0.stall_cnt, 3);
    step(idle);
    chk("nofwd cnt wrap", bus0.stall_cnt, 0);
    chk("nofwd resume pc_en", bus0.pc_en, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
